// File: rtl/data_cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_types: shared types and geometry for the data cache.
//   - state_e : controller states (IDLE, CHECK, WRITEBACK, FILL)
//   - line_t  : one 256-bit cache line
//   - tag_t   : stored tag
//   - word_be : expands a 4-bit word byte-enable into a 32-bit line byte-enable
// -----------------------------------------------------------------------------
package cache_types;

  localparam int S_OFFSET   = 5;                      // byte-offset bits per line
  localparam int S_INDEX    = 4;                      // set-index bits
  localparam int S_TAG      = 32 - S_OFFSET - S_INDEX; // 23
  localparam int NUM_SETS   = 1 << S_INDEX;           // 16
  localparam int LINE_BYTES = 1 << S_OFFSET;          // 32
  localparam int LINE_BITS  = 8 * LINE_BYTES;         // 256
  localparam int WORDS      = LINE_BYTES / 4;         // 8

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    FILL
  } state_e;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [S_TAG-1:0]     tag_t;

  // Place a word's byte enables at that word's position within the line.
  function automatic logic [LINE_BYTES-1:0] word_be(input logic [2:0] word,
                                                    input logic [3:0] be);
    logic [LINE_BYTES-1:0] mask;
    mask = '0;
    mask[{word, 2'b00} +: 4] = be;
    return mask;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// -----------------------------------------------------------------------------
// dcache_array: storage for NUM_SETS entries of {valid, dirty, tag, line}.
// Ports:
//   clk, rst_ni       clock; async active-low clear of valid/dirty bits only
//   index_i           set index shared by the read and write ports
//   valid_o/dirty_o   combinational read of the indexed entry
//   tag_o/line_o
//   valid_we_i/valid_i, dirty_we_i/dirty_i, tag_we_i/tag_i
//                     per-field write strobes and data
//   line_be_i/line_i  per-byte write enables and data for the line
// -----------------------------------------------------------------------------
module dcache_array
  import cache_types::*;
(
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic [S_INDEX-1:0]    index_i,
  output logic                  valid_o,
  output logic                  dirty_o,
  output tag_t                  tag_o,
  output line_t                 line_o,
  input  logic                  valid_we_i,
  input  logic                  valid_i,
  input  logic                  dirty_we_i,
  input  logic                  dirty_i,
  input  logic                  tag_we_i,
  input  tag_t                  tag_i,
  input  logic [LINE_BYTES-1:0] line_be_i,
  input  line_t                 line_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  tag_t                tag_q  [NUM_SETS];
  line_t               line_q [NUM_SETS];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_we_i) valid_q[index_i] <= valid_i;
      if (dirty_we_i) dirty_q[index_i] <= dirty_i;
    end
  end

  // Tag and data are left unreset; valid gates their use.
  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[index_i] <= tag_i;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (line_be_i[b]) line_q[index_i][b*8 +: 8] <= line_i[b*8 +: 8];
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign line_o  = line_q[index_i];

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache: direct-mapped, write-back, write-allocate data cache.
// CPU side (responder): mem_read/mem_write held until the one-cycle mem_resp;
//   mem_address is word aligned, mem_byte_enable selects write lanes,
//   mem_rdata is valid only while mem_resp=1 and is zero otherwise.
// Memory side (initiator): pmem_read (fill) / pmem_write (writeback) held
//   until pmem_resp; pmem_address is line aligned; 256-bit pmem_wdata/rdata.
// rst is asynchronous and active low.
// -----------------------------------------------------------------------------
module data_cache
  import cache_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output line_t       pmem_wdata,
  input  logic        pmem_resp,
  input  line_t       pmem_rdata
);

  state_e      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;

  // Byte-within-word bits are never used by a word-aligned cache.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_address[1:0];

  tag_t               req_tag;
  logic [S_INDEX-1:0] req_index;
  logic [2:0]         req_word;
  assign req_tag   = addr_q[31:9];
  assign req_index = addr_q[8:5];
  assign req_word  = addr_q[4:2];

  logic                  arr_valid, arr_dirty;
  tag_t                  arr_tag;
  line_t                 arr_line;
  logic                  arr_valid_we, arr_valid_in;
  logic                  arr_dirty_we, arr_dirty_in;
  logic                  arr_tag_we;
  logic [LINE_BYTES-1:0] arr_line_be;
  line_t                 arr_line_in;
  logic                  hit;

  dcache_array u_array (
    .clk        (clk),
    .rst_ni     (rst),
    .index_i    (req_index),
    .valid_o    (arr_valid),
    .dirty_o    (arr_dirty),
    .tag_o      (arr_tag),
    .line_o     (arr_line),
    .valid_we_i (arr_valid_we),
    .valid_i    (arr_valid_in),
    .dirty_we_i (arr_dirty_we),
    .dirty_i    (arr_dirty_in),
    .tag_we_i   (arr_tag_we),
    .tag_i      (req_tag),
    .line_be_i  (arr_line_be),
    .line_i     (arr_line_in)
  );

  assign hit = arr_valid && (arr_tag == req_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    write_d      = write_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    arr_valid_we = 1'b0;
    arr_valid_in = 1'b0;
    arr_dirty_we = 1'b0;
    arr_dirty_in = 1'b0;
    arr_tag_we   = 1'b0;
    arr_line_be  = '0;
    // Replicating the word lets the byte mask alone pick its position.
    arr_line_in  = {WORDS{wdata_q}};

    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = mem_address[31:2];
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          write_d = mem_write;   // write wins if both are asserted
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (hit) begin
          mem_resp = 1'b1;
          if (write_q) begin
            arr_line_be  = word_be(req_word, be_q);
            arr_dirty_we = 1'b1;
            arr_dirty_in = 1'b1;
          end else begin
            mem_rdata = arr_line[{req_word, 5'b00000} +: 32];
          end
          state_d = IDLE;
        end else if (arr_valid && arr_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {arr_tag, req_index, 5'b00000};
        pmem_wdata   = arr_line;
        if (pmem_resp) begin
          arr_dirty_we = 1'b1;
          state_d      = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_index, 5'b00000};
        if (pmem_resp) begin
          arr_line_be  = '1;
          arr_line_in  = pmem_rdata;
          arr_tag_we   = 1'b1;
          arr_valid_we = 1'b1;
          arr_valid_in = 1'b1;
          arr_dirty_we = 1'b1;
          state_d      = CHECK;   // re-check now hits
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
